// File: rtl/demux_buffered_pkg.sv
// Shared definitions for the buffered 1-to-2 demultiplexer.
package demux_buffered_pkg;

  localparam int unsigned DEMUX_DEPTH = 2;

  typedef enum logic {
    CH1 = 1'b0,
    CH2 = 1'b1
  } ch_e;

endpackage

// File: rtl/demux_fifo2.sv
// Two-entry FIFO with a registered head word that holds the last popped value when empty.
module demux_fifo2
  import demux_buffered_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [width-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'(DEMUX_DEPTH));
  assign empty   = (count == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      // Head register tracks the word that will be at the front next cycle.
      if (do_push && (empty || (do_pop && count == 2'd1)))
        dout <= din;
      else if (do_pop && count == 2'd2)
        dout <= mem[~rd_ptr];
    end
  end

endmodule

// File: rtl/demux_buffered.sv
// 1-to-2 routing demux with a 2-entry buffer per channel.
// Define DEMUX_STATS_EN to add the per-channel delivery counters CNT1/CNT2.
module demux_buffered
  import demux_buffered_pkg::*;
#(
  parameter int width = 32
`ifdef DEMUX_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [width-1:0] IN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             sel,
  output logic [width-1:0] OUT1,
  output logic             OUT1_VALID,
  input  logic             OUT1_READY,
  output logic [width-1:0] OUT2,
  output logic             OUT2_VALID,
  input  logic             OUT2_READY
`ifdef DEMUX_STATS_EN
  , output logic [CNT_W-1:0] CNT1
  , output logic [CNT_W-1:0] CNT2
`endif
);

  logic full1, full2, empty1, empty2;
  logic push1, push2, pop1, pop2;

  // Readiness depends only on the selected buffer, never on consumer readiness.
  assign IN_READY   = (sel == CH2) ? ~full2 : ~full1;
  assign push1      = IN_VALID & IN_READY & (sel == CH1);
  assign push2      = IN_VALID & IN_READY & (sel == CH2);
  assign OUT1_VALID = ~empty1;
  assign OUT2_VALID = ~empty2;
  assign pop1       = OUT1_VALID & OUT1_READY;
  assign pop2       = OUT2_VALID & OUT2_READY;

  demux_fifo2 #(.width(width)) u_fifo1 (
    .clk   (CLK),
    .rst_n (RST),
    .push  (push1),
    .pop   (pop1),
    .din   (IN),
    .dout  (OUT1),
    .full  (full1),
    .empty (empty1)
  );

  demux_fifo2 #(.width(width)) u_fifo2 (
    .clk   (CLK),
    .rst_n (RST),
    .push  (push2),
    .pop   (pop2),
    .din   (IN),
    .dout  (OUT2),
    .full  (full2),
    .empty (empty2)
  );

`ifdef DEMUX_STATS_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CNT1 <= '0;
      CNT2 <= '0;
    end else begin
      if (pop1) CNT1 <= CNT1 + CNT_W'(1);
      if (pop2) CNT2 <= CNT2 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_demux_buffered.sv
// Self-checking bench for demux_buffered against a queue-based reference model.
// Define DEMUX_STATS_EN to also exercise the delivery counters (CNT_W=4).
module tb_demux_buffered;

  localparam int W = 32;
`ifdef DEMUX_STATS_EN
  localparam int CW = 4;
`endif

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] IN;
  logic         IN_VALID;
  logic         IN_READY;
  logic         sel;
  logic [W-1:0] OUT1;
  logic         OUT1_VALID;
  logic         OUT1_READY;
  logic [W-1:0] OUT2;
  logic         OUT2_VALID;
  logic         OUT2_READY;
`ifdef DEMUX_STATS_EN
  logic [CW-1:0] CNT1;
  logic [CW-1:0] CNT2;
`endif

  always #5 CLK = ~CLK;

`ifdef DEMUX_STATS_EN
  demux_buffered #(.width(W), .CNT_W(CW)) dut (
`else
  demux_buffered #(.width(W)) dut (
`endif
    .CLK        (CLK),
    .RST        (RST),
    .IN         (IN),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .sel        (sel),
    .OUT1       (OUT1),
    .OUT1_VALID (OUT1_VALID),
    .OUT1_READY (OUT1_READY),
    .OUT2       (OUT2),
    .OUT2_VALID (OUT2_VALID),
    .OUT2_READY (OUT2_READY)
`ifdef DEMUX_STATS_EN
    , .CNT1     (CNT1)
    , .CNT2     (CNT2)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: each channel is a bounded queue of depth 2.
  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];
  int delivered1 = 0;
  int delivered2 = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, compare with the model, then advance the model.
  task automatic cycle(input logic s, input logic v, input logic [W-1:0] d,
                       input logic r1, input logic r2);
    logic exp_ready, acc, p1, p2;
    @(negedge CLK);
    sel = s; IN_VALID = v; IN = d; OUT1_READY = r1; OUT2_READY = r2;
    #1;
    exp_ready = s ? (q2.size() < 2) : (q1.size() < 2);
    check("in_ready", {63'd0, IN_READY}, {63'd0, exp_ready});
    check("out1_valid", {63'd0, OUT1_VALID}, {63'd0, q1.size() != 0});
    check("out2_valid", {63'd0, OUT2_VALID}, {63'd0, q2.size() != 0});
    if (q1.size() != 0) check("out1_data", {32'd0, OUT1}, {32'd0, q1[0]});
    if (q2.size() != 0) check("out2_data", {32'd0, OUT2}, {32'd0, q2[0]});
`ifdef DEMUX_STATS_EN
    check("cnt1", {60'd0, CNT1}, 64'(delivered1 % (1 << CW)));
    check("cnt2", {60'd0, CNT2}, 64'(delivered2 % (1 << CW)));
`endif
    acc = v & exp_ready;
    p1  = r1 & (q1.size() != 0);
    p2  = r2 & (q2.size() != 0);
    @(posedge CLK);
    if (p1) begin void'(q1.pop_front()); delivered1++; end
    if (p2) begin void'(q2.pop_front()); delivered2++; end
    if (acc) begin
      if (s) q2.push_back(d);
      else   q1.push_back(d);
    end
    #1;
  endtask

  initial begin
    RST = 1'b0; IN = '0; IN_VALID = 1'b0; sel = 1'b0;
    OUT1_READY = 1'b0; OUT2_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out1_valid", {63'd0, OUT1_VALID}, 64'd0);
    check("rst_out2_valid", {63'd0, OUT2_VALID}, 64'd0);
    check("rst_out1", {32'd0, OUT1}, 64'd0);
    check("rst_out2", {32'd0, OUT2}, 64'd0);
    check("rst_in_ready", {63'd0, IN_READY}, 64'd1);
    @(negedge CLK);
    RST = 1'b1;

    // Single word to channel 1, visible one cycle later.
    cycle(1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    check("t1_out1", {32'd0, OUT1}, 64'hA5A5_0001);
    check("t1_out1_valid", {63'd0, OUT1_VALID}, 64'd1);
    check("t1_out2_valid", {63'd0, OUT2_VALID}, 64'd0);

    // Fill channel 2; channel 1 remains open.
    cycle(1'b1, 1'b1, 32'hB000_0001, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'hB000_0002, 1'b0, 1'b0);
    check("t2_ready_full2", {63'd0, IN_READY}, 64'd0);
    cycle(1'b1, 1'b1, 32'hB000_0003, 1'b0, 1'b0);
    check("t2_out2_head", {32'd0, OUT2}, 64'hB000_0001);
    cycle(1'b0, 1'b1, 32'hA5A5_0002, 1'b0, 1'b0);
    check("t2_q1_len", 64'(q1.size()), 64'd2);

    // Channel 1 to count 1, then push and pop together.
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("t3_head", {32'd0, OUT1}, 64'hA5A5_0002);
    cycle(1'b0, 1'b1, 32'hC0DE_0003, 1'b1, 1'b0);
    check("t3_out1_new", {32'd0, OUT1}, 64'hC0DE_0003);
    check("t3_out1_valid", {63'd0, OUT1_VALID}, 64'd1);
    check("t3_ready_count1", {63'd0, IN_READY}, 64'd1);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 1000; i++)
      cycle(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));

    // Fill both buffers, then reset mid-stream.
    for (int i = 0; i < 12 && (q1.size() < 2 || q2.size() < 2); i++)
      cycle(1'(i), 1'b1, $urandom, 1'b0, 1'b0);
    check("t5_q1_full", 64'(q1.size()), 64'd2);
    check("t5_q2_full", 64'(q2.size()), 64'd2);
    @(negedge CLK);
    IN_VALID = 1'b0;
    #2 RST = 1'b0;
    #1;
    check("t5_out1_valid", {63'd0, OUT1_VALID}, 64'd0);
    check("t5_out2_valid", {63'd0, OUT2_VALID}, 64'd0);
    check("t5_out1", {32'd0, OUT1}, 64'd0);
    check("t5_out2", {32'd0, OUT2}, 64'd0);
    q1.delete(); q2.delete();
    delivered1 = 0; delivered2 = 0;
    @(negedge CLK);
    RST = 1'b1;
    sel = 1'b0; #1;
    check("t5_ready_sel0", {63'd0, IN_READY}, 64'd1);
    sel = 1'b1; #1;
    check("t5_ready_sel1", {63'd0, IN_READY}, 64'd1);

`ifdef DEMUX_STATS_EN
    // Counter wrap: 17 deliveries on channel 1 with CNT_W=4.
    for (int i = 0; i < 200 && delivered1 < 17; i++)
      cycle(1'b0, 1'b1, 32'hD000_0000 + 32'(i), 1'b1, 1'b0);
    check("t6_delivered", 64'(delivered1), 64'd17);
    check("t6_cnt1_wrap", {60'd0, CNT1}, 64'd1);
    check("t6_cnt2", {60'd0, CNT2}, 64'd0);
`endif

    // Drain remaining words so they are also compared.
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
